and_reduce_checker: RTL and testbench
=====================================

// Module: and_reduce_checker
// PURPOSE
//  Self-checking response end for N-input AND gate blocks: sweeps every input
//  pattern 0..2^N-1 into a combinational DUT, samples the DUT output after a
//  settle delay, compares against &stim, and reports pass/fail with error
//  count and first failing pattern. Replaces open-loop $monitor benches with
//  a synthesizable checker usable in sim or on-board.
// PARAMETERS
//  N       4   DUT input width; pattern space is 2^N
//  SETTLE  1   cycles stim is held before sampling dut_y; legal range >=1
// PORTS
//  clk         in   1     single clock, all state on rising edge
//  rst         in   1     synchronous, active-high reset
//  start       in   1     one-cycle pulse; begins sweep when idle
//  dut_y       in   1     DUT output under test
//  stim        out  N     pattern driven to DUT inputs
//  busy        out  1     high from first DRIVE cycle through last SAMPLE
//  done        out  1     high after sweep completes; held until next start/rst
//  pass        out  1     valid when done: 1 iff err_count==0
//  err_count   out  N+1   mismatches this sweep (max 2^N, no saturation needed)
//  first_fail  out  N     stim value of first mismatch; valid when fail_valid
//  fail_valid  out  1     set on first mismatch, held until next start/rst
// BEHAVIOUR
//  Reset: state=IDLE; stim=0, busy=0, done=0, pass=0, err_count=0,
//   first_fail=0, fail_valid=0. Reset wins over every other event, any state.
//  FSM states: IDLE, DRIVE, SAMPLE, DONE.
//  IDLE/DONE + start: next cycle DRIVE, stim=0, settle_cnt=0, err_count=0,
//   fail_valid=0, first_fail=0, done=0, pass=0, busy=1.
//  DRIVE: hold stim; settle_cnt++; when settle_cnt==SETTLE-1 -> SAMPLE.
//  SAMPLE: expected=&stim; if dut_y!=expected: err_count++, and if
//   !fail_valid: first_fail=stim, fail_valid=1.
//   If stim=={N{1}} -> DONE (busy=0, done=1, pass=(final err_count==0,
//   including this cycle's mismatch)); else stim++, settle_cnt=0 -> DRIVE.
//  Timing: SETTLE+1 cycles/pattern; start at cycle 0 -> done=1 at cycle
//   2^N*(SETTLE+1)+1 (N=4,SETTLE=1: cycle 33).
//  start while busy: ignored, no restart, no counter disturbance.
//  start in DONE: restarts sweep; all results cleared as from IDLE.
//  stim never wraps past {N{1}}; sweep terminates there. X on dut_y counts
//   as a mismatch in simulation (compare with !==).
// STRUCTURE
//  Package and_chk_pkg: state enum (IDLE,DRIVE,SAMPLE,DONE), function
//   sweep_cycles(N,SETTLE)=2^N*(SETTLE+1) for benches.
//  One sub-module: chk_settle_timer (SETTLE-cycle down counter, load/expire).
//  Pattern counter, error counter and first-fail capture live in top.
// TESTING
//  1 Good DUT (y=&stim), N=4,SETTLE=1, start@0 -> busy 1..32, done@33,
//    pass=1, err_count=0, fail_valid=0; stim visits 0..15 in order.
//  2 DUT stuck-at-0 -> err_count=1, first_fail=4'hF, pass=0.
//  3 DUT stuck-at-1 -> err_count=15, first_fail=4'h0, fail_valid=1, pass=0.
//  4 rst at cycle 10 mid-sweep -> next cycle all outputs at reset values,
//    IDLE; subsequent start gives full clean sweep as in test 1.
//  5 start pulsed at cycles 5 and 20 during sweep -> ignored, done@33; start
//    in DONE -> results cleared, new sweep done 33 cycles later.
//  6 SETTLE=3, DUT with 2-cycle registered delay -> pass=1, done@65;
//    same DUT with SETTLE=1 -> pass=0, err_count>0.

Source files
------------

// File: rtl/and_chk_pkg.sv
// Shared types and helpers for the AND-reduce response checker.
package and_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } chk_state_t;

    // Cycles from the first DRIVE cycle through the last SAMPLE cycle.
    function automatic int sweep_cycles(input int n, input int settle);
        return (1 << n) * (settle + 1);
    endfunction

endpackage

// File: rtl/chk_settle_timer.sv
// Settle down-counter: loaded on entry to DRIVE, expires after SETTLE enabled cycles.
module chk_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= LOAD_VAL;
        else if (i_en && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_expire = i_en && (r_cnt == '0);

endmodule

// File: rtl/and_reduce_checker.sv
// Sweeps all 2^N patterns into a combinational AND block and checks dut_y == &stim.
module and_reduce_checker
    import and_chk_pkg::*;
#(
    parameter int N      = 4,
    parameter int SETTLE = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_dut_y,
    output logic [N-1:0] o_stim,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_pass,
    output logic [N:0]   o_err_count,
    output logic [N-1:0] o_first_fail,
    output logic         o_fail_valid
);
    chk_state_t r_state, w_next;

    logic [N-1:0] r_stim;
    logic         r_busy, r_done, r_pass, r_fail_valid;
    logic [N:0]   r_err_count;
    logic [N-1:0] r_first_fail;

    logic         w_load, w_expire, w_mismatch, w_last;
    logic [N:0]   w_err_next;

    chk_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_load),
        .i_en     (r_state == DRIVE),
        .o_expire (w_expire)
    );

    // Case inequality so an X on dut_y is scored as a mismatch in simulation.
    assign w_mismatch = (i_dut_y !== (&r_stim));
    assign w_last     = (r_stim == {N{1'b1}});
    assign w_err_next = r_err_count + {{N{1'b0}}, w_mismatch};

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_next = DRIVE;
                    w_load = 1'b1;
                end
            end
            DRIVE: begin
                if (w_expire)
                    w_next = SAMPLE;
            end
            SAMPLE: begin
                if (w_last) begin
                    w_next = DONE;
                end else begin
                    w_next = DRIVE;
                    w_load = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stim       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_first_fail <= '0;
            r_fail_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_stim       <= '0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_err_count  <= '0;
                        r_first_fail <= '0;
                        r_fail_valid <= 1'b0;
                    end
                end
                SAMPLE: begin
                    r_err_count <= w_err_next;
                    if (w_mismatch && !r_fail_valid) begin
                        r_first_fail <= r_stim;
                        r_fail_valid <= 1'b1;
                    end
                    // Verdict includes a mismatch on the final pattern.
                    if (w_last) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (w_err_next == '0);
                    end else begin
                        r_stim <= r_stim + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_stim       = r_stim;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_pass       = r_pass;
    assign o_err_count  = r_err_count;
    assign o_first_fail = r_first_fail;
    assign o_fail_valid = r_fail_valid;

endmodule

// File: tb/tb_and_reduce_checker.sv
// Scoreboard bench: two checker instances (SETTLE=1 and SETTLE=3) against switchable DUT models.
module tb_and_reduce_checker;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst, start1, start3;
    int   mode;   // 0 good, 1 stuck-0, 2 stuck-1, 3 two-cycle registered delay
    int   sel;    // 0 -> SETTLE=1 instance, 1 -> SETTLE=3 instance

    always #5 clk = ~clk;

    logic [N-1:0] stim1, ff1, stim3, ff3;
    logic         busy1, done1, pass1, fv1, busy3, done3, pass3, fv3;
    logic [N:0]   ec1, ec3;
    logic         y1, y3, d1a, d1b, d3a, d3b;

    always_ff @(posedge clk) begin
        d1a <= &stim1; d1b <= d1a;
        d3a <= &stim3; d3b <= d3a;
    end

    always_comb begin
        case (mode)
            0:       begin y1 = &stim1; y3 = &stim3; end
            1:       begin y1 = 1'b0;   y3 = 1'b0;   end
            2:       begin y1 = 1'b1;   y3 = 1'b1;   end
            default: begin y1 = d1b;    y3 = d3b;    end
        endcase
    end

    and_reduce_checker #(.N(N), .SETTLE(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_dut_y(y1),
        .o_stim(stim1), .o_busy(busy1), .o_done(done1), .o_pass(pass1),
        .o_err_count(ec1), .o_first_fail(ff1), .o_fail_valid(fv1)
    );

    and_reduce_checker #(.N(N), .SETTLE(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_start(start3), .i_dut_y(y3),
        .o_stim(stim3), .o_busy(busy3), .o_done(done3), .o_pass(pass3),
        .o_err_count(ec3), .o_first_fail(ff3), .o_fail_valid(fv3)
    );

    logic [N-1:0] m_stim, m_ff;
    logic         m_busy, m_done, m_pass, m_fv;
    logic [N:0]   m_ec;
    assign m_stim = sel ? stim3 : stim1;
    assign m_ff   = sel ? ff3   : ff1;
    assign m_busy = sel ? busy3 : busy1;
    assign m_done = sel ? done3 : done1;
    assign m_pass = sel ? pass3 : pass1;
    assign m_fv   = sel ? fv3   : fv1;
    assign m_ec   = sel ? ec3   : ec1;

    typedef struct { int ec; int ff; int fv; int pass; int cyc; } res_t;
    res_t res_q[$];
    int   stim_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_y(input int md, input int p);
        case (md)
            0:       return &(4'(p));
            1:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic set_start(input bit v);
        if (sel != 0) start3 = v; else start1 = v;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_stim"}, stim1, 0);
        chk({tag, "_busy"}, busy1, 0);
        chk({tag, "_done"}, done1, 0);
        chk({tag, "_pass"}, pass1, 0);
        chk({tag, "_ec"},   ec1,   0);
        chk({tag, "_ff"},   ff1,   0);
        chk({tag, "_fv"},   fv1,   0);
    endtask

    // Push expectations, run one sweep, pop and compare at done.
    task automatic run_sweep(input int s, input bit pulse_mid, input bit chk_clear);
        res_t r;
        int   settle, n, bcnt, last;
        bit   have_last;
        sel    = s;
        settle = (s != 0) ? 3 : 1;
        r.ec = 0; r.ff = 0; r.fv = 0;
        if (mode == 3) begin
            if (settle >= 3) r.ec = 0; else begin r.ec = -1; r.fv = 1; r.ff = -1; end
        end else begin
            for (int p = 0; p < (1 << N); p++)
                if (model_y(mode, p) != (&(4'(p)))) begin
                    if (r.ec == 0) begin r.ff = p; r.fv = 1; end
                    r.ec++;
                end
        end
        r.pass = (r.ec == 0);
        r.cyc  = and_chk_pkg::sweep_cycles(N, settle) + 1;
        res_q.push_back(r);
        for (int p = 0; p < (1 << N); p++) stim_q.push_back(p);

        @(negedge clk); set_start(1'b1);
        @(negedge clk); set_start(1'b0);
        n = 1;
        if (chk_clear) begin
            chk("clr_done", m_done, 0);
            chk("clr_pass", m_pass, 0);
            chk("clr_ec",   m_ec,   0);
            chk("clr_fv",   m_fv,   0);
            chk("clr_ff",   m_ff,   0);
        end
        chk("busy_first", m_busy, 1);
        bcnt = 0; have_last = 0; last = 0;
        while (!m_done && n < 400) begin
            if (m_busy) begin
                bcnt++;
                if (!have_last || int'(m_stim) != last) begin
                    if (stim_q.size() == 0) chk("stim_extra", m_stim, 'hFFFF);
                    else chk("stim_order", m_stim, stim_q.pop_front());
                    last = int'(m_stim);
                    have_last = 1;
                end
            end
            set_start(pulse_mid && (n == 5 || n == 20));
            @(negedge clk);
            n++;
        end
        set_start(1'b0);
        r = res_q.pop_front();
        chk("done_cycle", n, r.cyc);
        chk("busy_cycles", bcnt, r.cyc - 1);
        chk("busy_end", m_busy, 0);
        chk("stim_left", stim_q.size(), 0);
        if (r.ec < 0) chk("ec_nonzero", (m_ec != 0), 1);
        else          chk("err_count", m_ec, r.ec);
        if (r.ff >= 0) chk("first_fail", m_ff, r.ff);
        chk("fail_valid", m_fv, r.fv);
        chk("pass", m_pass, r.pass);
        stim_q.delete();
    endtask

    initial begin
        int n;
        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; mode = 0; sel = 0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        chk("rst3_busy", busy3, 0);
        chk("rst3_done", done3, 0);
        rst = 1'b0;

        mode = 0; run_sweep(0, 0, 0);   // good DUT
        mode = 1; run_sweep(0, 0, 1);   // stuck-at-0
        mode = 2; run_sweep(0, 0, 1);   // stuck-at-1
        mode = 0; run_sweep(0, 1, 1);   // starts during busy ignored; restart from DONE

        // Reset mid-sweep.
        sel = 0;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        n = 1;
        while (n < 10) begin @(negedge clk); n++; end
        chk("mid_busy", busy1, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        rst = 1'b0;
        run_sweep(0, 0, 0);

        // Registered-delay DUT: long settle passes, short settle fails.
        mode = 3; run_sweep(1, 0, 0);
        mode = 3; run_sweep(0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
